morra_match_driver: RTL and testbench
=====================================

Name: morra_match_driver

Overview:
- Initiator side of the MorraCinese game interface: launches a match, drives legal move pairs on P1/P2 and watches GAME for the match result.
- Runs its own scoreboard of the game rules and reports a mismatch when the game's result disagrees with it.
- Sits between a bench or top-level controller (GO/CFG) and the game block; used for self-test and autoplay.

Parameters:
- SEED, 16'hACE1, LFSR load value; a value of 0 is replaced by 16'h0001.
- LAUNCH_GAP, 2, number of cycles after START during which P1=P2=00 and START=0.
- TIMEOUT, 40, number of WAIT_END cycles before the block gives up on GAME.

Ports:
- clk  in  1  clock
- RST  in  1  synchronous, active-high reset
- GO  in  1  request to run one match; ignored while BUSY
- CFG_EXTRA  in  4  number of rounds beyond 4; sampled on GO
- FORCE_EN  in  1  use FORCE_P1/FORCE_P2 instead of the LFSR moves
- FORCE_P1  in  2  forced move for P1
- FORCE_P2  in  2  forced move for P2
- ROUND  in  2  game round outcome (monitored only)
- GAME  in  2  game match result; 00 means the match is still running
- P1  out  2  move to game
- P2  out  2  move to game
- START  out  1  match launch strobe to game
- BUSY  out  1  high from LAUNCH through REPORT
- DONE  out  1  one-cycle pulse at end of match
- RESULT  out  2  latched GAME value
- EXP_RESULT  out  2  result computed by the internal model
- MISMATCH  out  1  RESULT differs from EXP_RESULT
- TIMEOUT_ERR  out  1  GAME never went nonzero

Behaviour:
- Encodings: 00 NONE, 01 ROCK, 10 PAPER, 11 SCISSORS.
  - P1 wins on {P1,P2} = 0111, 1001, 1110.
  - P2 wins on 1101, 0110, 1011.
  - Equal moves are a draw.
- Reset: every output is 0, state is IDLE, LFSR is loaded with SEED. Reset mid-match aborts in the next cycle with P1=P2=00, so the game only sees invalid moves.
- IDLE:
  - P1=P2=00, START=0.
  - GO → LAUNCH. MISMATCH, TIMEOUT_ERR and RESULT clear on that transition.
- LAUNCH (exactly 1 cycle):
  - START=1, {P1,P2}=CFG_EXTRA.
  - Model init: PLAYED=0, TO_PLAY=CFG_EXTRA+4 (5-bit), ADV=4 (4-bit), PREV_WIN=00, PREV_MOVE=00.
  - → GAP.
- GAP: LAUNCH_GAP cycles with P1=P2=00 and START=0, then → PLAY.
- PLAY: one legal pair per cycle, registered, so a pair is visible the cycle after it is chosen.
  - Raw moves: FORCE_* when FORCE_EN=1, otherwise LFSR[1:0] for P1 and LFSR[3:2] for P2. A raw value of 00 maps to 01.
  - Legality fix: if PREV_WIN=01 and the P1 move equals PREV_MOVE, rotate the P1 move (01→10→11→01). Apply the same rule to P2 when PREV_WIN=10.
  - P1 win: ADV+1, PREV_WIN=01, PREV_MOVE=P1.
  - P2 win: ADV−1, PREV_WIN=10, PREV_MOVE=P2.
  - Draw: PREV_WIN=PREV_MOVE=00.
  - Every issued pair increments PLAYED.
  - LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, stepped once per PLAY cycle.
  - Continue condition, evaluated after each update: PLAYED<4, or (3≤ADV≤5 and PLAYED<TO_PLAY). When it is false → WAIT_END.
  - EXP_RESULT: ADV>4 → 01, ADV<4 → 10, ADV=4 → 11. It is set on leaving PLAY.
- WAIT_END:
  - P1=P2=00.
  - GAME≠00 → latch RESULT=GAME, set MISMATCH=(GAME≠EXP_RESULT), → REPORT.
  - After TIMEOUT cycles with GAME=00: TIMEOUT_ERR=1, RESULT=00, MISMATCH=0, → REPORT.
- REPORT: DONE=1 for one cycle, → IDLE. RESULT, EXP_RESULT and the error flags hold until the next GO.
- Width rules:
  - TO_PLAY max is 19 (fits 5 bits).
  - ADV stays within 0..8 (4-bit unsigned, no wrap).
  - PLAYED saturates at 31.
  - The TIMEOUT counter is $clog2(TIMEOUT+1) bits wide.
- ROUND is not used for control.

Decomposition:
- morra_pkg holds:
  - move and outcome encodings;
  - BASE_ROUNDS=4, ADV_INIT=4, ADV_LO=3, ADV_HI=5;
  - the state enum IDLE/LAUNCH/GAP/PLAY/WAIT_END/REPORT;
  - the function winner(p1,p2) returning 00/01/10/11.
- Sub-module morra_ref_model holds the PLAYED/ADV/PREV_* scoreboard, the continue predicate and EXP_RESULT. The LFSR and the FSM stay inline.

Test Plan:
- Reset: hold RST 2 cycles mid-PLAY → next cycle P1=P2=00, START=0, BUSY=0, DONE=0, RESULT=00, no further moves.
- Launch: GO with CFG_EXTRA=0101 → START=1 with P1=01, P2=01 for exactly 1 cycle, then 2 cycles of 00/00, BUSY=1 throughout.
- All draws: FORCE_EN=1, FORCE 01/01, CFG_EXTRA=0 → exactly 4 pairs 01/01, EXP_RESULT=11. Bench returns GAME=11 → DONE pulse, RESULT=11, MISMATCH=0.
- Legality rotation: FORCE P1=10, P2=01, CFG_EXTRA=0 → pairs 10/01, 11/01, 10/10, 10/01, then stop with EXP_RESULT=01.
- Mismatch: same as the rotation case but the bench answers GAME=10 → RESULT=10, MISMATCH=1, DONE pulse.
- Timeout, with TIMEOUT=40: GAME held 00 → after 40 WAIT_END cycles TIMEOUT_ERR=1, RESULT=00, DONE pulse. A GO during BUSY is ignored.

Source files
------------

// File: rtl/morra_pkg.sv
// Shared encodings, constants, FSM state type and rule helpers for the
// MorraCinese match driver.
package morra_pkg;

    localparam logic [1:0] MOVE_NONE     = 2'b00;
    localparam logic [1:0] MOVE_ROCK     = 2'b01;
    localparam logic [1:0] MOVE_PAPER    = 2'b10;
    localparam logic [1:0] MOVE_SCISSORS = 2'b11;

    localparam logic [1:0] OUT_NONE = 2'b00;
    localparam logic [1:0] OUT_P1   = 2'b01;
    localparam logic [1:0] OUT_P2   = 2'b10;
    localparam logic [1:0] OUT_DRAW = 2'b11;

    localparam logic [4:0] BASE_ROUNDS = 5'd4;
    localparam logic [3:0] ADV_INIT    = 4'd4;
    localparam logic [3:0] ADV_LO      = 4'd3;
    localparam logic [3:0] ADV_HI      = 4'd5;
    localparam logic [3:0] ADV_MAX     = 4'd8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        GAP,
        PLAY,
        WAIT_END,
        REPORT
    } state_t;

    function automatic logic [1:0] winner(input logic [1:0] p1, input logic [1:0] p2);
        logic [1:0] res;
        res = OUT_NONE;
        if (p1 == MOVE_NONE || p2 == MOVE_NONE) begin
            res = OUT_NONE;
        end else if (p1 == p2) begin
            res = OUT_DRAW;
        end else if ({p1, p2} == 4'b0111 || {p1, p2} == 4'b1001 || {p1, p2} == 4'b1110) begin
            res = OUT_P1;
        end else begin
            res = OUT_P2;
        end
        return res;
    endfunction

    function automatic logic [1:0] rotate_move(input logic [1:0] m);
        logic [1:0] res;
        case (m)
            MOVE_ROCK:  res = MOVE_PAPER;
            MOVE_PAPER: res = MOVE_SCISSORS;
            default:    res = MOVE_ROCK;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] adv_to_result(input logic [3:0] adv);
        logic [1:0] res;
        if (adv > ADV_INIT) begin
            res = OUT_P1;
        end else if (adv < ADV_INIT) begin
            res = OUT_P2;
        end else begin
            res = OUT_DRAW;
        end
        return res;
    endfunction

endpackage

// File: rtl/morra_ref_model.sv
// Scoreboard of the game rules: legalises raw moves, tracks the advantage
// and round count, and decides when the match is over and who should win.
module morra_ref_model
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_init,
    input  logic [3:0] i_cfg_extra,
    input  logic       i_step,
    input  logic [1:0] i_raw_p1,
    input  logic [1:0] i_raw_p2,
    output logic [1:0] o_p1,
    output logic [1:0] o_p2,
    output logic       o_continue,
    output logic [1:0] o_exp_result
);

    logic [4:0] r_played;
    logic [4:0] r_to_play;
    logic [3:0] r_adv;
    logic [1:0] r_prev_win;
    logic [1:0] r_prev_move;
    logic [1:0] r_exp;

    logic [1:0] w_win;
    logic [3:0] w_adv_next;
    logic [4:0] w_played_next;
    logic [1:0] w_prev_win_next;
    logic [1:0] w_prev_move_next;

    // A winner may not repeat its winning move in the very next round.
    always_comb begin
        o_p1 = (i_raw_p1 == MOVE_NONE) ? MOVE_ROCK : i_raw_p1;
        o_p2 = (i_raw_p2 == MOVE_NONE) ? MOVE_ROCK : i_raw_p2;
        if (r_prev_win == OUT_P1 && o_p1 == r_prev_move) begin
            o_p1 = rotate_move(o_p1);
        end
        if (r_prev_win == OUT_P2 && o_p2 == r_prev_move) begin
            o_p2 = rotate_move(o_p2);
        end
        w_win            = winner(o_p1, o_p2);
        w_adv_next       = r_adv;
        w_prev_win_next  = OUT_NONE;
        w_prev_move_next = MOVE_NONE;
        case (w_win)
            OUT_P1: begin
                if (r_adv != ADV_MAX) begin
                    w_adv_next = r_adv + 4'd1;
                end
                w_prev_win_next  = OUT_P1;
                w_prev_move_next = o_p1;
            end
            OUT_P2: begin
                if (r_adv != 4'd0) begin
                    w_adv_next = r_adv - 4'd1;
                end
                w_prev_win_next  = OUT_P2;
                w_prev_move_next = o_p2;
            end
            default: begin
            end
        endcase
        w_played_next = (r_played == 5'd31) ? r_played : r_played + 5'd1;
        o_continue    = (w_played_next < BASE_ROUNDS) ||
                        ((w_adv_next >= ADV_LO) && (w_adv_next <= ADV_HI) &&
                         (w_played_next < r_to_play));
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_played    <= '0;
            r_to_play   <= '0;
            r_adv       <= '0;
            r_prev_win  <= OUT_NONE;
            r_prev_move <= MOVE_NONE;
            r_exp       <= OUT_NONE;
        end else if (i_init) begin
            r_played    <= '0;
            r_to_play   <= 5'(i_cfg_extra) + BASE_ROUNDS;
            r_adv       <= ADV_INIT;
            r_prev_win  <= OUT_NONE;
            r_prev_move <= MOVE_NONE;
            r_exp       <= OUT_NONE;
        end else if (i_step) begin
            r_played    <= w_played_next;
            r_adv       <= w_adv_next;
            r_prev_win  <= w_prev_win_next;
            r_prev_move <= w_prev_move_next;
            if (!o_continue) begin
                r_exp <= adv_to_result(w_adv_next);
            end
        end
    end

    assign o_exp_result = r_exp;

endmodule

// File: rtl/morra_match_driver.sv
// Match initiator for the MorraCinese game: launches a match, plays legal
// move pairs and compares the game's verdict against the internal model.
module morra_match_driver
    import morra_pkg::*;
#(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          LAUNCH_GAP = 2,
    parameter int          TIMEOUT    = 40
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       GO,
    input  logic [3:0] CFG_EXTRA,
    input  logic       FORCE_EN,
    input  logic [1:0] FORCE_P1,
    input  logic [1:0] FORCE_P2,
    input  logic [1:0] ROUND,
    input  logic [1:0] GAME,
    output logic [1:0] P1,
    output logic [1:0] P2,
    output logic       START,
    output logic       BUSY,
    output logic       DONE,
    output logic [1:0] RESULT,
    output logic [1:0] EXP_RESULT,
    output logic       MISMATCH,
    output logic       TIMEOUT_ERR
);

    localparam int          GAP_W    = $clog2(LAUNCH_GAP + 1);
    localparam int          TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LAUNCH_GAP - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    state_t           r_state;
    state_t           w_state_next;
    logic [15:0]      r_lfsr;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [1:0]       r_p1;
    logic [1:0]       r_p2;
    logic [1:0]       r_result;
    logic             r_mismatch;
    logic             r_timeout;

    logic [1:0] w_p1_next;
    logic [1:0] w_p2_next;
    logic       w_model_init;
    logic       w_model_step;
    logic [1:0] w_raw_p1;
    logic [1:0] w_raw_p2;
    logic [1:0] w_model_p1;
    logic [1:0] w_model_p2;
    logic       w_model_cont;
    logic [1:0] w_model_exp;
    logic       w_game_seen;
    logic       w_timed_out;
    logic       w_lfsr_fb;
    logic       w_unused_round;

    assign w_lfsr_fb      = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_raw_p1       = FORCE_EN ? FORCE_P1 : r_lfsr[1:0];
    assign w_raw_p2       = FORCE_EN ? FORCE_P2 : r_lfsr[3:2];
    assign w_unused_round = ^ROUND;

    morra_ref_model u_model (
        .clk          (clk),
        .i_rst        (RST),
        .i_init       (w_model_init),
        .i_cfg_extra  (CFG_EXTRA),
        .i_step       (w_model_step),
        .i_raw_p1     (w_raw_p1),
        .i_raw_p2     (w_raw_p2),
        .o_p1         (w_model_p1),
        .o_p2         (w_model_p2),
        .o_continue   (w_model_cont),
        .o_exp_result (w_model_exp)
    );

    // Moves are registered, so the value chosen here appears one cycle later.
    always_comb begin
        w_state_next = r_state;
        w_p1_next    = MOVE_NONE;
        w_p2_next    = MOVE_NONE;
        w_model_init = 1'b0;
        w_model_step = 1'b0;
        w_game_seen  = 1'b0;
        w_timed_out  = 1'b0;
        case (r_state)
            IDLE: begin
                if (GO) begin
                    w_state_next           = LAUNCH;
                    w_model_init           = 1'b1;
                    {w_p1_next, w_p2_next} = CFG_EXTRA;
                end
            end
            LAUNCH: begin
                w_state_next = GAP;
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_next = PLAY;
                end
            end
            PLAY: begin
                w_model_step = 1'b1;
                w_p1_next    = w_model_p1;
                w_p2_next    = w_model_p2;
                if (!w_model_cont) begin
                    w_state_next = WAIT_END;
                end
            end
            WAIT_END: begin
                if (GAME != OUT_NONE) begin
                    w_game_seen  = 1'b1;
                    w_state_next = REPORT;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timed_out  = 1'b1;
                    w_state_next = REPORT;
                end
            end
            REPORT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state    <= IDLE;
            r_lfsr     <= SEED_EFF;
            r_gap_cnt  <= '0;
            r_to_cnt   <= '0;
            r_p1       <= MOVE_NONE;
            r_p2       <= MOVE_NONE;
            r_result   <= OUT_NONE;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_p1      <= w_p1_next;
            r_p2      <= w_p2_next;
            r_gap_cnt <= (r_state == GAP) ? r_gap_cnt + GAP_W'(1) : '0;
            r_to_cnt  <= (r_state == WAIT_END) ? r_to_cnt + TO_W'(1) : '0;
            if (r_state == PLAY) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            end
            if (w_model_init) begin
                r_result   <= OUT_NONE;
                r_mismatch <= 1'b0;
                r_timeout  <= 1'b0;
            end
            if (w_game_seen) begin
                r_result   <= GAME;
                r_mismatch <= (GAME != w_model_exp);
            end
            if (w_timed_out) begin
                r_result   <= OUT_NONE;
                r_mismatch <= 1'b0;
                r_timeout  <= 1'b1;
            end
        end
    end

    assign P1          = r_p1;
    assign P2          = r_p2;
    assign START       = (r_state == LAUNCH);
    assign BUSY        = (r_state != IDLE);
    assign DONE        = (r_state == REPORT);
    assign RESULT      = r_result;
    assign EXP_RESULT  = w_model_exp;
    assign MISMATCH    = r_mismatch;
    assign TIMEOUT_ERR = r_timeout;

endmodule

// File: tb/tb_morra_match_driver.sv
// Directed bench for morra_match_driver: table of forced matches with
// hand-computed pairs and results, plus timeout, reset and LFSR-driven runs.
module tb_morra_match_driver;

    logic       clk = 1'b0;
    logic       RST;
    logic       GO;
    logic [3:0] CFG_EXTRA;
    logic       FORCE_EN;
    logic [1:0] FORCE_P1;
    logic [1:0] FORCE_P2;
    logic [1:0] ROUND;
    logic [1:0] GAME;
    logic [1:0] P1;
    logic [1:0] P2;
    logic       START;
    logic       BUSY;
    logic       DONE;
    logic [1:0] RESULT;
    logic [1:0] EXP_RESULT;
    logic       MISMATCH;
    logic       TIMEOUT_ERR;

    int checks = 0;
    int passed = 0;

    logic [3:0] seen[32];
    int         seenCount;

    typedef struct {
        logic [3:0]  cfg;
        logic        fen;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [1:0]  game;
        int          npairs;
        logic [31:0] pairs;
        logic [1:0]  expRes;
        logic [1:0]  result;
        logic        mm;
    } vec_t;

    vec_t vecs[7];

    morra_match_driver #(
        .SEED       (16'hACE1),
        .LAUNCH_GAP (2),
        .TIMEOUT    (40)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .GO          (GO),
        .CFG_EXTRA   (CFG_EXTRA),
        .FORCE_EN    (FORCE_EN),
        .FORCE_P1    (FORCE_P1),
        .FORCE_P2    (FORCE_P2),
        .ROUND       (ROUND),
        .GAME        (GAME),
        .P1          (P1),
        .P2          (P2),
        .START       (START),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .RESULT      (RESULT),
        .EXP_RESULT  (EXP_RESULT),
        .MISMATCH    (MISMATCH),
        .TIMEOUT_ERR (TIMEOUT_ERR)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] benchWinner(input logic [1:0] a, input logic [1:0] b);
        if (a == b) return 2'b11;
        if ((a == 2'd1 && b == 2'd3) || (a == 2'd2 && b == 2'd1) || (a == 2'd3 && b == 2'd2)) return 2'b01;
        return 2'b10;
    endfunction

    function automatic vec_t mk(input logic [3:0] cfg, input logic fen, input logic [1:0] f1,
                                input logic [1:0] f2, input logic [1:0] game, input int npairs,
                                input logic [31:0] pairs, input logic [1:0] expRes,
                                input logic [1:0] result, input logic mm);
        vec_t v;
        v.cfg = cfg; v.fen = fen; v.f1 = f1; v.f2 = f2; v.game = game;
        v.npairs = npairs; v.pairs = pairs; v.expRes = expRes; v.result = result; v.mm = mm;
        return v;
    endfunction

    // GO pulse followed by the launch cycle and the two quiet gap cycles.
    task automatic launchMatch(input string tag, input logic [3:0] cfg, input logic fen,
                               input logic [1:0] f1, input logic [1:0] f2);
        FORCE_EN = fen; FORCE_P1 = f1; FORCE_P2 = f2; CFG_EXTRA = cfg; GO = 1'b1;
        tick();
        GO = 1'b0;
        checkOutput({tag, " launch START/BUSY"}, {START, BUSY}, 2'b11);
        checkOutput({tag, " launch pair"}, {P1, P2}, cfg);
        checkOutput({tag, " launch flags cleared"}, {MISMATCH, TIMEOUT_ERR, RESULT}, 4'b0000);
        for (int g = 0; g < 2; g++) begin
            tick();
            checkOutput($sformatf("%s gap%0d", tag, g), {START, BUSY, P1, P2}, 6'b010000);
        end
    endtask

    task automatic collectPairs();
        int guard;
        guard = 0;
        seenCount = 0;
        tick();
        while ({P1, P2} == 4'd0 && guard < 4) begin
            tick();
            guard++;
        end
        while ({P1, P2} != 4'd0 && seenCount < 32) begin
            seen[seenCount] = {P1, P2};
            seenCount++;
            tick();
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        launchMatch(tag, v.cfg, v.fen, v.f1, v.f2);
        collectPairs();
        checkOutput({tag, " pair count"}, seenCount, v.npairs);
        for (int k = 0; k < seenCount; k++) begin
            if (k < 8 && k < v.npairs) begin
                checkOutput($sformatf("%s pair%0d", tag, k), seen[k], v.pairs[31-4*k -: 4]);
            end
        end
        checkOutput({tag, " EXP_RESULT"}, EXP_RESULT, v.expRes);
        GAME = v.game;
        tick();
        checkOutput({tag, " report"}, {DONE, BUSY, RESULT, MISMATCH, TIMEOUT_ERR},
                    {1'b1, 1'b1, v.result, v.mm, 1'b0});
        GAME = 2'b00;
        tick();
        checkOutput({tag, " DONE dropped"}, {DONE, BUSY}, 2'b00);
        checkOutput({tag, " results held"}, {RESULT, MISMATCH, EXP_RESULT}, {v.result, v.mm, v.expRes});
    endtask

    initial begin
        int n;
        int adv;
        int played;
        logic [1:0] pw;
        logic [1:0] pm;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] w;
        logic       cont;
        logic [1:0] benchExp;

        RST = 1'b1; GO = 1'b0; CFG_EXTRA = 4'd0; FORCE_EN = 1'b0;
        FORCE_P1 = 2'd0; FORCE_P2 = 2'd0; ROUND = 2'd0; GAME = 2'd0;

        vecs[0] = mk(4'd0, 1'b1, 2'd1, 2'd1, 2'b11, 4, 32'h5555_0000, 2'b11, 2'b11, 1'b0);
        vecs[1] = mk(4'd0, 1'b1, 2'd2, 2'd1, 2'b01, 4, 32'h9DA9_0000, 2'b01, 2'b01, 1'b0);
        vecs[2] = mk(4'd0, 1'b1, 2'd2, 2'd1, 2'b10, 4, 32'h9DA9_0000, 2'b01, 2'b10, 1'b1);
        vecs[3] = mk(4'd0, 1'b1, 2'd3, 2'd2, 2'b01, 4, 32'hE6FE_0000, 2'b01, 2'b01, 1'b0);
        vecs[4] = mk(4'd3, 1'b1, 2'd1, 2'd3, 2'b01, 7, 32'h7B57_B570, 2'b01, 2'b01, 1'b0);
        vecs[5] = mk(4'd5, 1'b1, 2'd0, 2'd0, 2'b11, 9, 32'h5555_5555, 2'b11, 2'b11, 1'b0);
        vecs[6] = mk(4'd0, 1'b1, 2'd1, 2'd2, 2'b10, 4, 32'h67A6_0000, 2'b10, 2'b10, 1'b0);

        tick();
        tick();
        checkOutput("reset outputs", {P1, P2, START, BUSY, DONE, RESULT, EXP_RESULT, MISMATCH, TIMEOUT_ERR}, 14'd0);
        RST = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], i);
            tick();
        end

        // Timeout: GAME stays 00, and a GO pulse during BUSY must be ignored.
        launchMatch("timeout", 4'd0, 1'b1, 2'd1, 2'd1);
        collectPairs();
        checkOutput("timeout pair count", seenCount, 4);
        n = 0;
        GO = 1'b1;
        while (!DONE && n < 60) begin
            tick();
            GO = 1'b0;
            n++;
        end
        checkOutput("timeout wait cycles", n, 39);
        checkOutput("timeout report", {DONE, TIMEOUT_ERR, RESULT, MISMATCH}, 5'b11000);
        tick();
        checkOutput("timeout DONE dropped", {DONE, BUSY, TIMEOUT_ERR}, 3'b001);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("GO in BUSY ignored %0d", k), {START, BUSY}, 2'b00);
        end

        // Reset in the middle of PLAY.
        launchMatch("reset", 4'd0, 1'b1, 2'd1, 2'd1);
        n = 0;
        while ({P1, P2} == 4'd0 && n < 6) begin
            tick();
            n++;
        end
        checkOutput("reset pre pair seen", {P1, P2}, 4'b0101);
        RST = 1'b1;
        tick();
        checkOutput("reset mid-play", {P1, P2, START, BUSY, DONE, RESULT, MISMATCH, TIMEOUT_ERR}, 11'd0);
        tick();
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("post reset idle %0d", k), {P1, P2, START, BUSY, DONE}, 7'd0);
        end

        // LFSR-driven match: check legality, stop point and result by rule.
        launchMatch("lfsr", 4'd3, 1'b0, 2'd0, 2'd0);
        collectPairs();
        adv = 4; played = 0; pw = 2'b00; pm = 2'b00; cont = 1'b1;
        for (int k = 0; k < seenCount; k++) begin
            a = seen[k][3:2];
            b = seen[k][1:0];
            checkOutput($sformatf("lfsr pair%0d moves valid", k), (a != 2'd0) && (b != 2'd0), 1);
            checkOutput($sformatf("lfsr pair%0d legal", k), (pw == 2'b01 && a == pm) || (pw == 2'b10 && b == pm), 0);
            w = benchWinner(a, b);
            if (w == 2'b01) begin adv++; pw = 2'b01; pm = a; end
            else if (w == 2'b10) begin adv--; pw = 2'b10; pm = b; end
            else begin pw = 2'b00; pm = 2'b00; end
            played++;
            cont = (played < 4) || (adv >= 3 && adv <= 5 && played < 7);
            checkOutput($sformatf("lfsr pair%0d continue", k), cont, (k != seenCount - 1));
        end
        checkOutput("lfsr pair count range", (seenCount >= 4) && (seenCount <= 7), 1);
        benchExp = (adv > 4) ? 2'b01 : ((adv < 4) ? 2'b10 : 2'b11);
        checkOutput("lfsr EXP_RESULT", EXP_RESULT, benchExp);
        GAME = benchExp;
        tick();
        checkOutput("lfsr report", {DONE, RESULT, MISMATCH}, {1'b1, benchExp, 1'b0});
        GAME = 2'b00;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
